// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX hazard sources in, stall/flush/bubble controls out.
interface hazard_if;
    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_uses_rs1_i;
    logic       id_uses_rs2_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_mem_read_i;
    logic       ex_redirect_i;
    logic       ex_muldiv_i;
    logic       ex_is_div_i;
    logic       pc_stall_o;
    logic       if_id_stall_o;
    logic       if_id_flush_o;
    logic       id_ex_bubble_o;
    logic       id_ex_flush_en_o;
    logic       id_ex_stall_o;
    logic       ex_mem_bubble_o;
    logic       muldiv_busy_o;
    logic       muldiv_done_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_rd_addr_i, ex_mem_read_i, ex_redirect_i, ex_muldiv_i, ex_is_div_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, id_ex_flush_en_o,
               id_ex_stall_o, ex_mem_bubble_o, muldiv_busy_o, muldiv_done_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_rd_addr_i, ex_mem_read_i, ex_redirect_i, ex_muldiv_i, ex_is_div_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, id_ex_flush_en_o,
               id_ex_stall_o, ex_mem_bubble_o, muldiv_busy_o, muldiv_done_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, redirect flush, multi-cycle mul/div stall sequencing
// and saturating performance counters.
module hazard_unit #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_if.slave          hz,
    output logic [CNT_W-1:0] load_use_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] muldiv_stall_cnt_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [6:0] MUL_L = 7'(MUL_LAT);
    localparam logic [6:0] DIV_L = 7'(DIV_LAT);

    state_t           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] muldiv_stall_cnt_q, muldiv_stall_cnt_d;

    logic [6:0] lat;
    logic       start, load_use, stall_grp, done, redirect, bubble;

    always_comb begin
        lat       = hz.ex_is_div_i ? DIV_L : MUL_L;
        start     = (state_q == IDLE) && hz.ex_muldiv_i;
        load_use  = hz.ex_mem_read_i && (hz.ex_rd_addr_i != 5'd0) &&
                    ((hz.id_uses_rs1_i && (hz.id_rs1_addr_i == hz.ex_rd_addr_i)) ||
                     (hz.id_uses_rs2_i && (hz.id_rs2_addr_i == hz.ex_rd_addr_i)));
        // Reset gates every control output so a pipeline in reset sees no stalls or flushes.
        stall_grp = !rst && ((start && (lat > 7'd1)) ||
                             ((state_q == BUSY) && (cnt_q != 7'd1)));
        done      = !rst && ((start && (lat == 7'd1)) ||
                             ((state_q == BUSY) && (cnt_q == 7'd1)));
        redirect  = !rst && !stall_grp && hz.ex_redirect_i;
        bubble    = !rst && !stall_grp && !hz.ex_redirect_i && load_use;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && (lat > 7'd1)) begin
                    state_d = BUSY;
                    cnt_d   = lat - 7'd1;
                end
            end
            BUSY: begin
                if (cnt_q == 7'd1) begin
                    state_d = IDLE;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 7'd0;
            end
        endcase

        load_use_cnt_d     = load_use_cnt_q;
        flush_cnt_d        = flush_cnt_q;
        muldiv_stall_cnt_d = muldiv_stall_cnt_q;
        if (bubble && (load_use_cnt_q != '1))
            load_use_cnt_d = load_use_cnt_q + 1'b1;
        if (redirect && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (stall_grp && (muldiv_stall_cnt_q != '1))
            muldiv_stall_cnt_d = muldiv_stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= 7'd0;
            load_use_cnt_q     <= '0;
            flush_cnt_q        <= '0;
            muldiv_stall_cnt_q <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            load_use_cnt_q     <= load_use_cnt_d;
            flush_cnt_q        <= flush_cnt_d;
            muldiv_stall_cnt_q <= muldiv_stall_cnt_d;
        end
    end

    assign hz.pc_stall_o       = stall_grp || bubble;
    assign hz.if_id_stall_o    = stall_grp || bubble;
    assign hz.if_id_flush_o    = redirect;
    assign hz.id_ex_bubble_o   = bubble;
    assign hz.id_ex_flush_en_o = redirect;
    assign hz.id_ex_stall_o    = stall_grp;
    assign hz.ex_mem_bubble_o  = stall_grp;
    assign hz.muldiv_busy_o    = stall_grp;
    assign hz.muldiv_done_o    = done;

    assign load_use_cnt_o     = load_use_cnt_q;
    assign flush_cnt_o        = flush_cnt_q;
    assign muldiv_stall_cnt_o = muldiv_stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: default-parameter instance plus a MUL_LAT=1/CNT_W=4 instance.
module tb_hazard_unit;

    logic clk_sys = 1'b0;
    logic rst_a, rst_b;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] lu_cnt_a, fl_cnt_a, md_cnt_a;
    logic [3:0]  lu_cnt_b, fl_cnt_b, md_cnt_b;

    always #5 clk_sys = ~clk_sys;

    hazard_if ifa ();
    hazard_if ifb ();

    hazard_unit u_dut_a (
        .clk                (clk_sys),
        .rst                (rst_a),
        .hz                 (ifa.slave),
        .load_use_cnt_o     (lu_cnt_a),
        .flush_cnt_o        (fl_cnt_a),
        .muldiv_stall_cnt_o (md_cnt_a)
    );

    hazard_unit #(.MUL_LAT(1), .CNT_W(4)) u_dut_b (
        .clk                (clk_sys),
        .rst                (rst_b),
        .hz                 (ifb.slave),
        .load_use_cnt_o     (lu_cnt_b),
        .flush_cnt_o        (fl_cnt_b),
        .muldiv_stall_cnt_o (md_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_a();
        ifa.id_rs1_addr_i = 5'd0; ifa.id_rs2_addr_i = 5'd0;
        ifa.id_uses_rs1_i = 1'b0; ifa.id_uses_rs2_i = 1'b0;
        ifa.ex_rd_addr_i  = 5'd0; ifa.ex_mem_read_i = 1'b0;
        ifa.ex_redirect_i = 1'b0; ifa.ex_muldiv_i   = 1'b0;
        ifa.ex_is_div_i   = 1'b0;
    endtask

    task automatic clear_b();
        ifb.id_rs1_addr_i = 5'd0; ifb.id_rs2_addr_i = 5'd0;
        ifb.id_uses_rs1_i = 1'b0; ifb.id_uses_rs2_i = 1'b0;
        ifb.ex_rd_addr_i  = 5'd0; ifb.ex_mem_read_i = 1'b0;
        ifb.ex_redirect_i = 1'b0; ifb.ex_muldiv_i   = 1'b0;
        ifb.ex_is_div_i   = 1'b0;
    endtask

    task automatic lu_a(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
        ifa.ex_mem_read_i = 1'b1; ifa.ex_rd_addr_i  = rd;
        ifa.id_rs1_addr_i = rs1;  ifa.id_uses_rs1_i = u1;
        ifa.id_rs2_addr_i = rs2;  ifa.id_uses_rs2_i = u2;
    endtask

    task automatic reset_a();
        clear_a();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        #1;
    endtask

    // 9-bit packed view of all one-bit controls of instance A, ordered as in the interface.
    function automatic logic [8:0] outs_a();
        return {ifa.pc_stall_o, ifa.if_id_stall_o, ifa.if_id_flush_o, ifa.id_ex_bubble_o,
                ifa.id_ex_flush_en_o, ifa.id_ex_stall_o, ifa.ex_mem_bubble_o,
                ifa.muldiv_busy_o, ifa.muldiv_done_o};
    endfunction

    int done_seen;

    initial begin
        clear_a();
        clear_b();
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        step();

        // outputs held low during reset even with a live load-use hazard and an op
        lu_a(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        ifa.ex_redirect_i = 1'b1;
        ifa.ex_muldiv_i   = 1'b1;
        #1;
        chk("rst_outs", 32'(outs_a()), 32'd0);
        chk("rst_lu_cnt", 32'(lu_cnt_a), 32'd0);
        chk("rst_md_cnt", 32'(md_cnt_a), 32'd0);
        clear_a();
        rst_a = 1'b0;
        #1;

        // load-use on rs2
        lu_a(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        chk("lu_rs2_outs", 32'(outs_a()), 32'b1_1_0_1_0_0_0_0_0);
        step();
        clear_a();
        #1;
        chk("lu_after_outs", 32'(outs_a()), 32'd0);
        chk("lu_cnt_1", 32'(lu_cnt_a), 32'd1);

        // rd = x0 never stalls
        lu_a(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        chk("lu_x0_stall", 32'(ifa.pc_stall_o), 32'd0);
        step();
        clear_a();

        // match on rs1 only counts when rs1 is used
        lu_a(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        #1;
        chk("lu_rs1_unused", 32'(ifa.id_ex_bubble_o), 32'd0);
        ifa.id_uses_rs1_i = 1'b1;
        #1;
        chk("lu_rs1_used", 32'(ifa.id_ex_bubble_o), 32'd1);
        step();
        clear_a();
        #1;
        chk("lu_cnt_2", 32'(lu_cnt_a), 32'd2);

        // redirect overrides simultaneous load-use
        reset_a();
        lu_a(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        ifa.ex_redirect_i = 1'b1;
        #1;
        chk("redir_outs", 32'(outs_a()), 32'b0_0_1_0_1_0_0_0_0);
        step();
        clear_a();
        #1;
        chk("redir_fl_cnt", 32'(fl_cnt_a), 32'd1);
        chk("redir_lu_cnt", 32'(lu_cnt_a), 32'd0);

        // divide held 34 cycles: 33 stall cycles then done
        reset_a();
        ifa.ex_muldiv_i = 1'b1;
        ifa.ex_is_div_i = 1'b1;
        for (int k = 0; k < 34; k++) begin
            if (k == 5) begin
                lu_a(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
                ifa.ex_redirect_i = 1'b1;
            end
            if (k == 6) begin
                ifa.ex_mem_read_i = 1'b0;
                ifa.ex_redirect_i = 1'b0;
                ifa.ex_is_div_i   = 1'b0;
            end
            #1;
            if (k < 33)
                chk($sformatf("div_stall_c%0d", k), 32'(outs_a()), 32'b1_1_0_0_0_1_1_1_0);
            else
                chk("div_done", 32'(outs_a()), 32'b0_0_0_0_0_0_0_0_1);
            step();
        end

        // back-to-back multiply: 2 stall cycles, done in its 3rd
        ifa.ex_is_div_i = 1'b0;
        #1;
        chk("div_md_cnt", 32'(md_cnt_a), 32'd33);
        chk("div_masked_fl", 32'(fl_cnt_a), 32'd0);
        chk("div_masked_lu", 32'(lu_cnt_a), 32'd0);
        chk("mul_c0", 32'(outs_a()), 32'b1_1_0_0_0_1_1_1_0);
        step();
        chk("mul_c1", 32'(outs_a()), 32'b1_1_0_0_0_1_1_1_0);
        step();
        chk("mul_c2", 32'(outs_a()), 32'b0_0_0_0_0_0_0_0_1);
        step();
        ifa.ex_muldiv_i = 1'b0;
        #1;
        chk("mul_after", 32'(outs_a()), 32'd0);
        chk("mul_md_cnt", 32'(md_cnt_a), 32'd35);

        // reset in the 10th cycle of a divide aborts it
        reset_a();
        ifa.ex_muldiv_i = 1'b1;
        ifa.ex_is_div_i = 1'b1;
        for (int k = 0; k < 9; k++) step();
        rst_a = 1'b1;
        #1;
        chk("abort_rst_outs", 32'(outs_a()), 32'd0);
        step();
        rst_a = 1'b0;
        clear_a();
        #1;
        chk("abort_outs", 32'(outs_a()), 32'd0);
        chk("abort_md_cnt", 32'(md_cnt_a), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (ifa.muldiv_done_o || ifa.muldiv_busy_o) done_seen++;
            step();
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // MUL_LAT=1 instance: done same cycle, never stalls, every held cycle is a new op
        rst_b = 1'b0;
        ifb.ex_muldiv_i = 1'b1;
        #1;
        chk("lat1_done", 32'(ifb.muldiv_done_o), 32'd1);
        chk("lat1_busy", 32'(ifb.muldiv_busy_o), 32'd0);
        chk("lat1_stall", 32'(ifb.pc_stall_o), 32'd0);
        step();
        chk("lat1_done2", 32'(ifb.muldiv_done_o), 32'd1);
        chk("lat1_busy2", 32'(ifb.id_ex_stall_o), 32'd0);
        ifb.ex_muldiv_i = 1'b0;
        step();
        chk("lat1_md_cnt", 32'(md_cnt_b), 32'd0);

        // CNT_W=4 saturation over 20 load-use cycles
        ifb.ex_mem_read_i = 1'b1; ifb.ex_rd_addr_i = 5'd9;
        ifb.id_rs1_addr_i = 5'd9; ifb.id_uses_rs1_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 14) chk("sat_14", 32'(lu_cnt_b), 32'd14);
            step();
        end
        chk("sat_15", 32'(lu_cnt_b), 32'd15);
        clear_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
